// File: rtl/fc_layer_scheduler.sv
// Layer-pass sequencer for the FC datapath: input/weight address generation,
// MAC enable/load alignment with memory read data, and output write strobes.
module fc_layer_scheduler #(
    parameter int INNEURON                = 8,
    parameter int OUTNEURON               = 4,
    parameter int PI                      = 2,
    parameter int PO                      = 2,
    parameter int RD_LAT                  = 2,
    parameter int MAC_LAT                 = 1,
    parameter int FC_INNEURON_ADDR_WIDTH  = 8,
    parameter int FC_WEIGHT_ADDR_WIDTH    = 12,
    parameter int FC_OUTNEURON_ADDR_WIDTH = 8,
    parameter int BANK_SEL_WIDTH          = 5
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    output logic                               in_rden,
    output logic [FC_INNEURON_ADDR_WIDTH-1:0]  in_addr_a,
    output logic [FC_INNEURON_ADDR_WIDTH-1:0]  in_addr_b,
    output logic [BANK_SEL_WIDTH-1:0]          bank_sel,
    output logic                               w_rden,
    output logic [FC_WEIGHT_ADDR_WIDTH-1:0]    w_addr,
    output logic                               mac_en,
    output logic                               accum_sload,
    output logic                               out_wren,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] out_addr,
    output logic                               busy,
    output logic                               done
);

    localparam int K      = INNEURON / 2;
    localparam int BPB    = K / PI;
    localparam int G      = OUTNEURON / PO;
    localparam int DL     = RD_LAT + MAC_LAT;
    localparam int KW     = $clog2(K + 1);
    localparam int JW     = $clog2(BPB + 1);
    localparam int GW     = $clog2(G + 1);
    localparam int DW     = $clog2(DL + 1);
    localparam int BSR_W  = RD_LAT * BANK_SEL_WIDTH;

    if (PI < 1 || INNEURON % (2 * PI) != 0) begin : g_chk_in
        $error("INNEURON must be divisible by 2*PI");
    end
    if (PO < 1 || OUTNEURON % PO != 0) begin : g_chk_out
        $error("OUTNEURON must be divisible by PO");
    end
    if (BANK_SEL_WIDTH < $clog2(PI)) begin : g_chk_bank
        $error("BANK_SEL_WIDTH too small for PI banks");
    end
    if (RD_LAT < 1) begin : g_chk_lat
        $error("RD_LAT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        FIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [KW-1:0]                   beat;
    logic [JW-1:0]                   j;
    logic [BANK_SEL_WIDTH-1:0]       bank;
    logic [GW-1:0]                   grp;
    logic [DW-1:0]                   dcnt;
    logic [FC_WEIGHT_ADDR_WIDTH-1:0] w_cnt;

    logic [RD_LAT-1:0]                     rden_sr;
    logic [RD_LAT-1:0]                     sload_sr;
    logic [RD_LAT-1:0][BANK_SEL_WIDTH-1:0] bank_sr;

    logic                      run;
    logic                      first_beat;
    logic [BANK_SEL_WIDTH-1:0] bank_now;
    logic                      last_beat;
    logic                      last_j;
    logic                      last_drain;
    logic                      last_grp;

    assign run        = (state == RUN);
    assign first_beat = run && (beat == '0);
    assign bank_now   = run ? bank : '0;
    assign last_beat  = (beat == KW'(K - 1));
    assign last_j     = (j == JW'(BPB - 1));
    assign last_drain = (dcnt == DW'(DL - 1));
    assign last_grp   = (grp == GW'(G - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_beat) state_nx = DRAIN;
            DRAIN:   if (last_drain) state_nx = WRITE;
            WRITE:   state_nx = last_grp ? FIN : RUN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bank/local index advance as a nested counter pair, so k/BPB and k%BPB
    // never need a divider; everything rewinds on the last beat of a group.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            beat  <= '0;
            j     <= '0;
            bank  <= '0;
            grp   <= '0;
            dcnt  <= '0;
            w_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        beat  <= '0;
                        j     <= '0;
                        bank  <= '0;
                        grp   <= '0;
                        dcnt  <= '0;
                        w_cnt <= '0;
                    end
                end
                RUN: begin
                    w_cnt <= w_cnt + 1'b1;
                    dcnt  <= '0;
                    if (last_beat) begin
                        beat <= '0;
                        j    <= '0;
                        bank <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                        if (last_j) begin
                            j    <= '0;
                            bank <= bank + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end
                end
                DRAIN: dcnt <= dcnt + 1'b1;
                WRITE: if (!last_grp) grp <= grp + 1'b1;
                default: ;
            endcase
        end
    end

    // Read-side qualifiers travel RD_LAT stages so they line up with q data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rden_sr  <= '0;
            sload_sr <= '0;
            bank_sr  <= '0;
        end else begin
            rden_sr  <= RD_LAT'({rden_sr, run});
            sload_sr <= RD_LAT'({sload_sr, first_beat});
            bank_sr  <= BSR_W'({bank_sr, bank_now});
        end
    end

    always_comb begin
        in_rden     = run;
        w_rden      = run;
        in_addr_a   = '0;
        in_addr_b   = '0;
        w_addr      = '0;
        out_wren    = 1'b0;
        out_addr    = '0;
        if (run) begin
            in_addr_a = FC_INNEURON_ADDR_WIDTH'({j, 1'b0});
            in_addr_b = FC_INNEURON_ADDR_WIDTH'({j, 1'b1});
            w_addr    = w_cnt;
        end
        if (state == WRITE) begin
            out_wren = 1'b1;
            out_addr = FC_OUTNEURON_ADDR_WIDTH'(grp);
        end
        busy        = (state != IDLE);
        done        = (state == FIN);
        mac_en      = rden_sr[RD_LAT-1];
        accum_sload = sload_sr[RD_LAT-1];
        bank_sel    = bank_sr[RD_LAT-1];
    end

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Self-checking bench for fc_layer_scheduler: a directed vector table, a reset
// abort sequence and randomized start/reset traffic against a timeline model.
module tb_fc_layer_scheduler;

    logic clock = 1'b0;
    logic reset_n;
    logic start;

    always #5 clock = ~clock;

    logic        d1_in_rden, d1_w_rden, d1_mac_en, d1_accum_sload, d1_out_wren, d1_busy, d1_done;
    logic [7:0]  d1_in_addr_a, d1_in_addr_b, d1_out_addr;
    logic [4:0]  d1_bank_sel;
    logic [11:0] d1_w_addr;

    logic        d2_in_rden, d2_w_rden, d2_mac_en, d2_accum_sload, d2_out_wren, d2_busy, d2_done;
    logic [7:0]  d2_in_addr_a, d2_in_addr_b, d2_out_addr;
    logic [4:0]  d2_bank_sel;
    logic [11:0] d2_w_addr;

    fc_layer_scheduler dut1 (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in_rden(d1_in_rden), .in_addr_a(d1_in_addr_a), .in_addr_b(d1_in_addr_b),
        .bank_sel(d1_bank_sel), .w_rden(d1_w_rden), .w_addr(d1_w_addr),
        .mac_en(d1_mac_en), .accum_sload(d1_accum_sload), .out_wren(d1_out_wren),
        .out_addr(d1_out_addr), .busy(d1_busy), .done(d1_done)
    );

    fc_layer_scheduler #(
        .INNEURON(6), .OUTNEURON(2), .PI(1), .PO(2), .RD_LAT(1), .MAC_LAT(2)
    ) dut2 (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in_rden(d2_in_rden), .in_addr_a(d2_in_addr_a), .in_addr_b(d2_in_addr_b),
        .bank_sel(d2_bank_sel), .w_rden(d2_w_rden), .w_addr(d2_w_addr),
        .mac_en(d2_mac_en), .accum_sload(d2_accum_sload), .out_wren(d2_out_wren),
        .out_addr(d2_out_addr), .busy(d2_busy), .done(d2_done)
    );

    typedef struct {
        int K;
        int BPB;
        int G;
        int RL;
        int DL;
    } cfg_t;

    typedef struct {
        int rden; int wr; int a; int b; int w; int mac; int sload;
        int bank; int wren; int oaddr; int busy; int done;
    } outs_t;

    typedef struct {
        bit st;
        int rden; int a; int b; int w; int mac; int sload;
        int bank; int wren; int oaddr; int busy; int done;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    t1 = -1;
    int    t2 = -1;
    cfg_t  c1, c2;
    outs_t act1, act2;
    vec_t  tbl[20];

    function automatic int plen(cfg_t c);
        return c.G * (c.K + c.DL + 1) + 1;
    endfunction

    function automatic bit is_idle(cfg_t c, int t);
        return (t < 0) || (t > plen(c));
    endfunction

    // t is the cycle offset from the cycle in which start was accepted.
    function automatic outs_t model(cfg_t c, int t);
        outs_t o;
        int p_len, q, g, p, td;
        o = '{default: 0};
        p_len = c.K + c.DL + 1;
        if (t < 1 || t > plen(c)) return o;
        o.busy = 1;
        o.done = (t == plen(c)) ? 1 : 0;
        q = t - 1;
        g = q / p_len;
        p = q % p_len;
        if (g < c.G && p < c.K) begin
            o.rden = 1;
            o.wr   = 1;
            o.a    = 2 * (p % c.BPB);
            o.b    = o.a + 1;
            o.w    = g * c.K + p;
        end
        if (g < c.G && p == c.K + c.DL) begin
            o.wren  = 1;
            o.oaddr = g;
        end
        td = t - c.RL;
        if (td >= 1) begin
            q = td - 1;
            g = q / p_len;
            p = q % p_len;
            if (g < c.G && p < c.K) begin
                o.mac   = 1;
                o.sload = (p == 0) ? 1 : 0;
                o.bank  = p / c.BPB;
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare(input string tag, input outs_t a, input outs_t e);
        chk({tag, ".in_rden"}, a.rden, e.rden);
        chk({tag, ".w_rden"}, a.wr, e.wr);
        chk({tag, ".mac_en"}, a.mac, e.mac);
        chk({tag, ".accum_sload"}, a.sload, e.sload);
        chk({tag, ".out_wren"}, a.wren, e.wren);
        chk({tag, ".busy"}, a.busy, e.busy);
        chk({tag, ".done"}, a.done, e.done);
        if (e.rden != 0) begin
            chk({tag, ".in_addr_a"}, a.a, e.a);
            chk({tag, ".in_addr_b"}, a.b, e.b);
            chk({tag, ".w_addr"}, a.w, e.w);
        end
        if (e.mac != 0) chk({tag, ".bank_sel"}, a.bank, e.bank);
        if (e.wren != 0) chk({tag, ".out_addr"}, a.oaddr, e.oaddr);
    endtask

    task automatic sample();
        act1 = '{d1_in_rden, d1_w_rden, d1_in_addr_a, d1_in_addr_b, d1_w_addr, d1_mac_en,
                 d1_accum_sload, d1_bank_sel, d1_out_wren, d1_out_addr, d1_busy, d1_done};
        act2 = '{d2_in_rden, d2_w_rden, d2_in_addr_a, d2_in_addr_b, d2_w_addr, d2_mac_en,
                 d2_accum_sload, d2_bank_sel, d2_out_wren, d2_out_addr, d2_busy, d2_done};
    endtask

    function automatic int any_nz(outs_t o);
        return o.rden | o.wr | o.a | o.b | o.w | o.mac | o.sload | o.bank |
               o.wren | o.oaddr | o.busy | o.done;
    endfunction

    // One clock cycle: drive inputs, check both DUTs at negedge, advance models.
    task automatic step(input bit s, input bit r);
        start   = s;
        reset_n = ~r;
        if (!r && s && is_idle(c1, t1)) t1 = 0;
        if (!r && s && is_idle(c2, t2)) t2 = 0;
        @(negedge clock);
        sample();
        compare("d1", act1, model(c1, t1));
        compare("d2", act2, model(c2, t2));
        @(posedge clock);
        #1;
        if (r) t1 = -1;
        else if (t1 >= 0) begin t1++; if (t1 > plen(c1)) t1 = -1; end
        if (r) t2 = -1;
        else if (t2 >= 0) begin t2++; if (t2 > plen(c2)) t2 = -1; end
        cyc++;
    endtask

    initial begin
        c1 = '{4, 2, 2, 2, 3};
        c2 = '{3, 3, 1, 1, 3};

        //          st rden a  b  w  mac sl bk wren oa busy done
        tbl[0]  = '{1, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0,   0};
        tbl[1]  = '{0, 1,   0, 1, 0, 0,  0, 0, 0,   0, 1,   0};
        tbl[2]  = '{0, 1,   2, 3, 1, 0,  0, 0, 0,   0, 1,   0};
        tbl[3]  = '{0, 1,   0, 1, 2, 1,  1, 0, 0,   0, 1,   0};
        tbl[4]  = '{0, 1,   2, 3, 3, 1,  0, 0, 0,   0, 1,   0};
        tbl[5]  = '{1, 0,   0, 0, 0, 1,  0, 1, 0,   0, 1,   0};
        tbl[6]  = '{0, 0,   0, 0, 0, 1,  0, 1, 0,   0, 1,   0};
        tbl[7]  = '{0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 1,   0};
        tbl[8]  = '{0, 0,   0, 0, 0, 0,  0, 0, 1,   0, 1,   0};
        tbl[9]  = '{0, 1,   0, 1, 4, 0,  0, 0, 0,   0, 1,   0};
        tbl[10] = '{0, 1,   2, 3, 5, 0,  0, 0, 0,   0, 1,   0};
        tbl[11] = '{0, 1,   0, 1, 6, 1,  1, 0, 0,   0, 1,   0};
        tbl[12] = '{1, 1,   2, 3, 7, 1,  0, 0, 0,   0, 1,   0};
        tbl[13] = '{0, 0,   0, 0, 0, 1,  0, 1, 0,   0, 1,   0};
        tbl[14] = '{0, 0,   0, 0, 0, 1,  0, 1, 0,   0, 1,   0};
        tbl[15] = '{0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 1,   0};
        tbl[16] = '{0, 0,   0, 0, 0, 0,  0, 0, 1,   1, 1,   0};
        tbl[17] = '{1, 0,   0, 0, 0, 0,  0, 0, 0,   0, 1,   1};
        tbl[18] = '{1, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0,   0};
        tbl[19] = '{0, 1,   0, 1, 0, 0,  0, 0, 0,   0, 1,   0};

        start   = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        step(0, 0);
        chk("reset_idle", any_nz(act1), 0);
        chk("reset_idle2", any_nz(act2), 0);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].st, 0);
            chk("tbl.rden", act1.rden, tbl[i].rden);
            chk("tbl.mac", act1.mac, tbl[i].mac);
            chk("tbl.sload", act1.sload, tbl[i].sload);
            chk("tbl.wren", act1.wren, tbl[i].wren);
            chk("tbl.busy", act1.busy, tbl[i].busy);
            chk("tbl.done", act1.done, tbl[i].done);
            if (tbl[i].rden != 0) begin
                chk("tbl.a", act1.a, tbl[i].a);
                chk("tbl.b", act1.b, tbl[i].b);
                chk("tbl.w", act1.w, tbl[i].w);
            end
            if (tbl[i].mac != 0) chk("tbl.bank", act1.bank, tbl[i].bank);
            if (tbl[i].wren != 0) chk("tbl.oaddr", act1.oaddr, tbl[i].oaddr);
            if (i >= 1 && i <= 3) chk("pi1.addr_a", act2.a, 2 * (i - 1));
            if (i <= 8) begin
                chk("pi1.mac", act2.mac, (i >= 2 && i <= 4) ? 1 : 0);
                chk("pi1.wren", act2.wren, (i == 7) ? 1 : 0);
                chk("pi1.done", act2.done, (i == 8) ? 1 : 0);
            end
        end
        repeat (20) step(0, 0);

        // Mid-pass reset abort, then restart from IDLE two cycles later.
        for (int rel = 0; rel <= 30; rel++) begin
            step(rel == 0 || rel == 12, rel == 10);
            if (rel == 11 || rel == 12) chk("abort.zero", any_nz(act1), 0);
            if (rel == 13) chk("abort.restart", act1.rden, 1);
            if (rel == 16) chk("abort.no_wren", act1.wren, 0);
            if (rel >= 11 && rel <= 28) chk("abort.no_done", act1.done, 0);
        end
        repeat (20) step(0, 0);

        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (30) step(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_scheduler.md
Name: fc_layer_scheduler

Overview:
- Sequences one fully-connected layer pass over the FC datapath: banked dual-port input-neuron memory, weight memory, PO-wide MAC array and output-neuron memory.
- On a start pulse it runs OUTNEURON/PO output groups. For each group it streams INNEURON/2 beats (two inputs per beat, ports a/b), aligns MAC enable and accumulator load with read data, then writes one output word.
- Sits between the layer-level top controller (start/done) and the memories/MAC array. It replaces free-running enable chains with an explicit FSM.

Parameters:
- INNEURON, 8, input neurons per layer; must be divisible by 2*PI (elaboration check).
- OUTNEURON, 4, output neurons; must be divisible by PO.
- PI, 2, number of input-neuron banks.
- PO, 2, outputs computed in parallel per group.
- RD_LAT, 2, memory read latency in cycles, from rden/addr to q valid.
- MAC_LAT, 1, cycles from the last mac_en beat to a valid accumulator result.
- FC_INNEURON_ADDR_WIDTH, 8, per-bank input address width.
- FC_WEIGHT_ADDR_WIDTH, 12, weight address width.
- FC_OUTNEURON_ADDR_WIDTH, 8, output address width.
- BANK_SEL_WIDTH, 5, bank select width; must be ≥ clog2(PI).

Ports:
- clock, in, 1, sole clock; all logic on posedge.
- reset_n, in, 1, synchronous active-low reset.
- start, in, 1, single-cycle request; sampled only in IDLE.
- in_rden, out, 1, read enable for both ports of all input banks.
- in_addr_a, out, FC_INNEURON_ADDR_WIDTH, per-bank port-a address.
- in_addr_b, out, FC_INNEURON_ADDR_WIDTH, per-bank port-b address.
- bank_sel, out, BANK_SEL_WIDTH, bank mux select; delayed RD_LAT cycles so it aligns with q data.
- w_rden, out, 1, weight read enable.
- w_addr, out, FC_WEIGHT_ADDR_WIDTH, weight address.
- mac_en, out, 1, MAC accumulate enable; aligned with q data.
- accum_sload, out, 1, load (not add) on the first beat of a group.
- out_wren, out, 1, output memory write strobe.
- out_addr, out, FC_OUTNEURON_ADDR_WIDTH, output group index.
- busy, out, 1, high while a pass is in progress.
- done, out, 1, one-cycle pulse at pass end.

Behaviour:
- Derived constants:
  - K = INNEURON/2 (beats per group).
  - BPB = K/PI (beats per bank).
  - G = OUTNEURON/PO (groups per pass).
- Reset (reset_n=0 at a clock edge):
  - FSM goes to IDLE; all counters clear.
  - Every output is 0.
  - Asserting reset mid-pass aborts immediately. No out_wren and no done are produced afterwards.
- FSM states: IDLE, RUN, DRAIN, WRITE, FIN.
  - IDLE: start=1 → RUN next cycle; beat k=0, group g=0. start in any other state is ignored.
  - RUN: lasts K cycles. Each cycle in_rden=w_rden=1 and k increments. After k=K-1 → DRAIN.
  - DRAIN: lasts RD_LAT+MAC_LAT cycles. rden signals are low.
  - WRITE: lasts 1 cycle. out_wren=1 and out_addr=g. If g<G-1 then g increments and k clears → RUN; otherwise → FIN.
  - FIN: lasts 1 cycle. done=1 → IDLE.
- Address generation uses counters only, no dividers:
  - Beat k maps to bank b = k / BPB and local index j = k mod BPB.
  - in_addr_a = 2j, in_addr_b = 2j+1.
  - w_addr = g*K + k, implemented as a running counter that is not reset between groups.
- Alignment:
  - mac_en and bank_sel are the RUN-cycle in_rden and bank b, delayed exactly RD_LAT cycles through a shift register.
  - accum_sload = mac_en on the delayed beat k=0.
- busy is 1 in RUN, DRAIN, WRITE and FIN; it is 0 only in IDLE.
- Pass length is 1 + G*(K+RD_LAT+MAC_LAT+1) cycles, counted from the start-sample cycle to the done cycle inclusive.
- When PI=1, bank_sel stays at 0.

Test Plan:
- Default params, start pulse at cycle 0:
  - in_rden high cycles 1–4 and 9–12.
  - mac_en high cycles 3–6 and 11–14; accum_sload high at cycles 3 and 11.
  - out_wren at cycle 8 (out_addr=0) and cycle 16 (out_addr=1).
  - done at cycle 17; busy high cycles 1–17.
- Address sequence, group 0 beats k=0..3:
  - in_addr_a = 0,2,0,2; in_addr_b = 1,3,1,3.
  - bank_sel (delayed) = 0,0,1,1.
  - w_addr = 0..3 in group 0 and 4..7 in group 1.
- start re-pulsed at cycles 5 and 12 during a pass → ignored: identical waveforms and a single done at 17. start at cycle 18 → a new pass with in_rden at cycle 19.
- reset_n low at cycle 10 for one cycle:
  - All outputs 0 from cycle 11.
  - No out_wren at 16; no done.
  - IDLE accepts start at cycle 12.
- PI=1, INNEURON=6, OUTNEURON=2, PO=2, RD_LAT=1, MAC_LAT=2:
  - K=3; in_addr_a = 0,2,4.
  - mac_en cycles 2–4.
  - out_wren at cycle 7; done at cycle 8.
- Back-to-back passes: start asserted in the same cycle done is high → ignored, because FIN is not IDLE. start on the next cycle → accepted.
